// File: rtl/tracklet_event_sequencer_if.sv
// Bundle of the event control, tracklet read and VM write signals of the
// tracklet event sequencer. The master side is the environment that starts
// events and issues router write requests. The slave side is the sequencer.
interface tracklet_event_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic              en_proc;
    logic [ADDR_W-1:0] n_items;
    logic [ADDR_W-1:0] read_tracklet;
    logic              read_valid;

    logic              vm_req_1;
    logic              vm_req_2;
    logic              vm_req_3;
    logic              vm_wr_en_1;
    logic              vm_wr_en_2;
    logic              vm_wr_en_3;
    logic [ADDR_W-1:0] vm_wr_add_1;
    logic [ADDR_W-1:0] vm_wr_add_2;
    logic [ADDR_W-1:0] vm_wr_add_3;
    logic              vm_full_1;
    logic              vm_full_2;
    logic              vm_full_3;

    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output en_proc, n_items, vm_req_1, vm_req_2, vm_req_3,
        input  read_tracklet, read_valid,
        input  vm_wr_en_1, vm_wr_en_2, vm_wr_en_3,
        input  vm_wr_add_1, vm_wr_add_2, vm_wr_add_3,
        input  vm_full_1, vm_full_2, vm_full_3,
        input  busy, done, overflow
    );

    modport slave (
        input  en_proc, n_items, vm_req_1, vm_req_2, vm_req_3,
        output read_tracklet, read_valid,
        output vm_wr_en_1, vm_wr_en_2, vm_wr_en_3,
        output vm_wr_add_1, vm_wr_add_2, vm_wr_add_3,
        output vm_full_1, vm_full_2, vm_full_3,
        output busy, done, overflow
    );
endinterface

// File: rtl/tracklet_event_sequencer.sv
// Tracklet event sequencer. A rising edge on en_proc starts an event. The
// block then reads n_items tracklets and waits LATENCY cycles for the router
// pipeline to drain. It finishes with a one-cycle done pulse. Three
// independent VM write channels allocate addresses with saturating counters.
// A request to a full memory is dropped and sets a sticky overflow flag.
//
// Optional feature: define TRACKLET_SEQ_ABORT_EN to add an abort input. The
// abort input returns READ or DRAIN to IDLE without a done pulse.
//
// state | meaning
// IDLE  | waiting for an armed rising edge on en_proc
// READ  | issuing tracklet reads 0 .. n_items-1, one per cycle
// DRAIN | LATENCY cycles for in-flight router writes to land
// DONE  | single-cycle completion pulse
module tracklet_event_sequencer #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 9
) (
    input logic clk,
    input logic reset,
`ifdef TRACKLET_SEQ_ABORT_EN
    input logic abort,
`endif
    tracklet_event_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   FULL_VAL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [3:0]        LAT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic                  en_q, en_d;
    logic                  armed_q, armed_d;
    logic [ADDR_W-1:0]     n_items_q, n_items_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [3:0]            lat_q, lat_d;
    logic [2:0][ADDR_W:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic                  start;
    logic                  clr;
    logic [2:0]            vm_req;
    logic [2:0]            vm_full;
    logic [2:0]            vm_wr_en;

    // Start edge: en_proc newly high. The armed flag blocks a start until
    // en_proc has been seen low, which covers en_proc held high through reset.
    always_comb begin
        en_d    = bus.en_proc;
        armed_d = armed_q | ~bus.en_proc;
        start   = bus.en_proc & ~en_q & armed_q;
    end

    // Event FSM: next state, latched item count, read address and drain timer.
    always_comb begin
        state_d   = state_q;
        n_items_d = n_items_q;
        rd_addr_d = rd_addr_q;
        lat_d     = lat_q;
        clr       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_items_d = bus.n_items;
                    rd_addr_d = '0;
                    clr       = 1'b1;
                    state_d   = (bus.n_items == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_addr_q == n_items_q - ONE_A) begin
                    state_d = S_DRAIN;
                    lat_d   = LAT_LOAD;
                end else begin
                    rd_addr_d = rd_addr_q + ONE_A;
                end
            end
            S_DRAIN: begin
                if (lat_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef TRACKLET_SEQ_ABORT_EN
        if (abort && (state_q == S_READ || state_q == S_DRAIN)) begin
            state_d = S_IDLE;
        end
`endif
    end

    // VM channels: qualify requests against full and advance the saturating
    // address counters. A start clears the counters and overflow. The clear
    // takes priority over a same-cycle write.
    always_comb begin
        vm_req = {bus.vm_req_3, bus.vm_req_2, bus.vm_req_1};
        cnt_d  = cnt_q;
        for (int k = 0; k < 3; k++) begin
            vm_full[k]  = (cnt_q[k] == FULL_VAL);
            vm_wr_en[k] = vm_req[k] & ~vm_full[k];
            cnt_d[k]    = clr ? '0 : cnt_q[k] + {{ADDR_W{1'b0}}, vm_wr_en[k]};
        end
        ovf_d = clr ? 1'b0 : (ovf_q | (|(vm_req & vm_full)));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            armed_q   <= 1'b0;
            n_items_q <= '0;
            rd_addr_q <= '0;
            lat_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            armed_q   <= armed_d;
            n_items_q <= n_items_d;
            rd_addr_q <= rd_addr_d;
            lat_q     <= lat_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Output decode.
    always_comb begin
        bus.read_tracklet = rd_addr_q;
        bus.read_valid    = (state_q == S_READ);
        bus.busy          = (state_q != S_IDLE);
        bus.done          = (state_q == S_DONE);
        bus.overflow      = ovf_q;
        bus.vm_wr_en_1    = vm_wr_en[0];
        bus.vm_wr_en_2    = vm_wr_en[1];
        bus.vm_wr_en_3    = vm_wr_en[2];
        bus.vm_full_1     = vm_full[0];
        bus.vm_full_2     = vm_full[1];
        bus.vm_full_3     = vm_full[2];
        bus.vm_wr_add_1   = cnt_q[0][ADDR_W-1:0];
        bus.vm_wr_add_2   = cnt_q[1][ADDR_W-1:0];
        bus.vm_wr_add_3   = cnt_q[2][ADDR_W-1:0];
    end

endmodule

// File: tb/tb_tracklet_event_sequencer.sv
// Self-checking bench for tracklet_event_sequencer. Event traces and VM
// address allocation are predicted from the block's rules with plain integer
// arithmetic. Stimulus is partly randomized.
module tb_tracklet_event_sequencer;

    localparam int ADDR_W = 9;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
`ifdef TRACKLET_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    tracklet_event_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    tracklet_event_sequencer #(.LATENCY(LAT), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef TRACKLET_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_cnt[3];
    bit m_ovf;

    function automatic int obs_add(int k);
        case (k)
            0:       return int'(bus.vm_wr_add_1);
            1:       return int'(bus.vm_wr_add_2);
            default: return int'(bus.vm_wr_add_3);
        endcase
    endfunction

    function automatic bit obs_en(int k);
        case (k)
            0:       return bus.vm_wr_en_1;
            1:       return bus.vm_wr_en_2;
            default: return bus.vm_wr_en_3;
        endcase
    endfunction

    function automatic bit obs_full(int k);
        case (k)
            0:       return bus.vm_full_1;
            1:       return bus.vm_full_2;
            default: return bus.vm_full_3;
        endcase
    endfunction

    task automatic test_reset();
        logic [40:0] obs;
        bus.en_proc  = 1'b0;
        bus.n_items  = '0;
        bus.vm_req_1 = 1'b0;
        bus.vm_req_2 = 1'b0;
        bus.vm_req_3 = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus.read_tracklet, bus.read_valid, bus.busy, bus.done, bus.overflow,
               bus.vm_wr_add_1, bus.vm_wr_add_2, bus.vm_wr_add_3,
               bus.vm_full_1, bus.vm_full_2, bus.vm_full_3};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h, want 0", obs);
        end
        reset = 1'b1;
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.read_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: busy/done/rv=%b, want 000",
                     {bus.busy, bus.done, bus.read_valid});
        end
    endtask

    // One event with n items. The expected trace is n read cycles, then LAT
    // drain cycles when n>0, then one done cycle. If repulse >= 0, en_proc is
    // pulsed again at that trace cycle, and the pulse must be ignored.
    task automatic test_event(int n, int repulse);
        int total;
        bit exp_rv, exp_busy, exp_done;
        int exp_addr;
        total = n + ((n > 0) ? LAT : 0) + 1;
        @(negedge clk);
        bus.n_items = ADDR_W'(n);
        bus.en_proc = 1'b1;
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_ovf = 1'b0;
        for (int c = 0; c <= total; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_rv   = (c < n);
            exp_busy = (c < total);
            exp_done = (c == total - 1);
            checks++;
            if ({bus.read_valid, bus.busy, bus.done} !== {exp_rv, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL event_ctrl n=%0d cyc=%0d: rv/busy/done=%b, want %b",
                         n, c, {bus.read_valid, bus.busy, bus.done},
                         {exp_rv, exp_busy, exp_done});
            end
            if (n > 0 && c < n + LAT) begin
                exp_addr = (c < n) ? c : n - 1;
                checks++;
                if (int'(bus.read_tracklet) != exp_addr) begin
                    errors++;
                    $display("FAIL event_addr n=%0d cyc=%0d: read_tracklet=%0d, want %0d",
                             n, c, bus.read_tracklet, exp_addr);
                end
            end
            if (c == 0) begin
                checks++;
                if (bus.overflow !== 1'b0 || obs_add(0) != 0 || obs_add(1) != 0 ||
                    obs_add(2) != 0 || bus.vm_full_2 !== 1'b0) begin
                    errors++;
                    $display("FAIL start_clear: ovf=%b add=%0d/%0d/%0d full2=%b, want all 0",
                             bus.overflow, obs_add(0), obs_add(1), obs_add(2), bus.vm_full_2);
                end
                bus.n_items = ADDR_W'($urandom_range(0, 20));
            end
            bus.en_proc = (c == repulse);
        end
        bus.en_proc = 1'b0;
    endtask

    task automatic test_sequences();
        int n, total, rp;
        test_event(5, -1);
        test_event(0, -1);
        test_event(1, -1);
        for (int i = 0; i < 6; i++) begin
            n     = $urandom_range(0, 12);
            total = n + ((n > 0) ? LAT : 0) + 1;
            rp    = (total >= 3 && $urandom_range(0, 1) == 1) ? $urandom_range(1, total - 2) : -1;
            test_event(n, rp);
        end
    endtask

    task automatic test_vm_fill();
        bit exp_full;
        int drops = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge clk);
            bus.vm_req_2 = 1'b1;
            #1;
            exp_full = (m_cnt[1] == DEPTH);
            checks++;
            if (obs_add(1) != (m_cnt[1] % DEPTH) || obs_en(1) !== !exp_full ||
                obs_full(1) !== exp_full) begin
                errors++;
                $display("FAIL fill_ch2 i=%0d: add=%0d en=%b full=%b, want add=%0d en=%b full=%b",
                         i, obs_add(1), obs_en(1), obs_full(1), m_cnt[1] % DEPTH,
                         !exp_full, exp_full);
            end
            if (!obs_en(1)) drops++;
            if (exp_full) m_ovf = 1'b1;
            else          m_cnt[1]++;
        end
        @(negedge clk);
        bus.vm_req_2 = 1'b0;
        #1;
        checks++;
        if (drops != 2 || bus.overflow !== 1'b1 || bus.vm_full_2 !== 1'b1) begin
            errors++;
            $display("FAIL fill_end: drops=%0d ovf=%b full2=%b, want 2 1 1",
                     drops, bus.overflow, bus.vm_full_2);
        end
        checks++;
        if (obs_add(0) != m_cnt[0] || obs_add(2) != m_cnt[2] ||
            bus.vm_full_1 !== 1'b0 || bus.vm_full_3 !== 1'b0) begin
            errors++;
            $display("FAIL fill_other_ch: add1=%0d add3=%0d full1=%b full3=%b, want %0d %0d 0 0",
                     obs_add(0), obs_add(2), bus.vm_full_1, bus.vm_full_3, m_cnt[0], m_cnt[2]);
        end
    endtask

    task automatic test_vm_random(int cycles);
        bit r[3];
        bit exp_full;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            foreach (r[k]) r[k] = 1'($urandom_range(0, 1));
            bus.vm_req_1 = r[0];
            bus.vm_req_2 = r[1];
            bus.vm_req_3 = r[2];
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_full = (m_cnt[k] == DEPTH);
                checks++;
                if (obs_add(k) != (m_cnt[k] % DEPTH) || obs_en(k) !== (r[k] && !exp_full) ||
                    obs_full(k) !== exp_full) begin
                    errors++;
                    $display("FAIL rand_ch%0d i=%0d: add=%0d en=%b full=%b, want %0d %b %b",
                             k + 1, i, obs_add(k), obs_en(k), obs_full(k),
                             m_cnt[k] % DEPTH, r[k] && !exp_full, exp_full);
                end
            end
            checks++;
            if (bus.overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_ovf i=%0d: overflow=%b, want %b", i, bus.overflow, m_ovf);
            end
            for (int k = 0; k < 3; k++) begin
                if (r[k]) begin
                    if (m_cnt[k] == DEPTH) m_ovf = 1'b1;
                    else                   m_cnt[k]++;
                end
            end
        end
        @(negedge clk);
        bus.vm_req_1 = 1'b0;
        bus.vm_req_2 = 1'b0;
        bus.vm_req_3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pre_ovf: overflow=%b, want 1", bus.overflow);
        end
        test_event(5, 2);
        test_event(3, 1);
        test_event(7, 4);
    endtask

    task automatic test_reset_midread();
        bit found = 1'b0;
        logic [40:0] obs;
        @(negedge clk);
        bus.n_items = ADDR_W'(8);
        bus.en_proc = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.read_valid === 1'b1 && bus.read_tracklet == ADDR_W'(3)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midread_reach: read_tracklet=%0d rv=%b, want 3 1",
                     bus.read_tracklet, bus.read_valid);
        end
        #2 reset = 1'b0;
        #1;
        obs = {bus.read_tracklet, bus.read_valid, bus.busy, bus.done, bus.overflow,
               bus.vm_wr_add_1, bus.vm_wr_add_2, bus.vm_wr_add_3,
               bus.vm_full_1, bus.vm_full_2, bus.vm_full_3};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h, want 0", obs);
        end
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.read_valid} !== 3'b000) begin
                errors++;
                $display("FAIL held_en_no_start i=%0d: busy/done/rv=%b, want 000",
                         i, {bus.busy, bus.done, bus.read_valid});
            end
        end
        bus.en_proc = 1'b0;
        @(negedge clk);
        bus.en_proc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.read_valid !== 1'b1 || bus.read_tracklet !== '0) begin
            errors++;
            $display("FAIL restart_after_toggle: busy=%b rv=%b addr=%0d, want 1 1 0",
                     bus.busy, bus.read_valid, bus.read_tracklet);
        end
        bus.en_proc = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL restart_done: done=%b, want 1 within 40 cycles", bus.done);
        end
        @(negedge clk);
    endtask

`ifdef TRACKLET_SEQ_ABORT_EN
    task automatic test_abort();
        bit found = 1'b0;
        @(negedge clk);
        bus.n_items = ADDR_W'(3);
        bus.en_proc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.en_proc  = 1'b0;
        bus.vm_req_1 = 1'b1;
        @(negedge clk);
        bus.vm_req_1 = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.read_valid === 1'b0 && bus.done === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_drain: busy=%b rv=%b, want 1 0", bus.busy, bus.read_valid);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || obs_add(0) != 1) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b add1=%0d, want 0 0 1",
                     bus.busy, bus.done, obs_add(0));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done i=%0d: done=%b busy=%b, want 0 0",
                         i, bus.done, bus.busy);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequences();
        test_vm_fill();
        test_vm_random(300);
        test_back_to_back();
        test_reset_midread();
`ifdef TRACKLET_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tracklet_event_sequencer.md
TRACKLET_EVENT_SEQUENCER -- requirements
Module: tracklet_event_sequencer

Interface
REQ-001 Parameter: LATENCY, default 2, cycles from the last tracklet read to the last routed VM write; legal 1..15.
REQ-002 Parameter: ADDR_W, default 9, address width for the tracklet memory and the VM projection memories.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en_proc  input  1  event start request; level input, only its rising edge is acted on.
REQ-006 n_items  input  ADDR_W  tracklet count for the event, sampled on the start edge.
REQ-007 read_tracklet  output  ADDR_W  tracklet memory read address.
REQ-008 read_valid  output  1  high in each cycle where read_tracklet carries a live read.
REQ-009 vm_req_1, vm_req_2, vm_req_3  input  1 each  write request from the router for VM memory k.
REQ-010 vm_wr_en_1, vm_wr_en_2, vm_wr_en_3  output  1 each  qualified write enable for VM memory k.
REQ-011 vm_wr_add_1, vm_wr_add_2, vm_wr_add_3  output  ADDR_W each  write address for VM memory k.
REQ-012 vm_full_1, vm_full_2, vm_full_3  output  1 each  VM memory k has no free entry left.
REQ-013 busy, done, overflow  output  1 each  event in progress / one-cycle completion pulse / sticky dropped-write flag.

Function
REQ-014 The state machine SHALL have four states: IDLE, READ, DRAIN, DONE.
REQ-015 A start edge SHALL be detected as en_proc high in the current cycle while it was low in the previous cycle, using a registered copy of en_proc.
REQ-016 IDLE: on a start edge, n_items SHALL be latched and the FSM SHALL go to READ if n_items is nonzero, or to DONE if it is zero.
REQ-017 On any start edge taken from IDLE, all VM address counters and overflow SHALL be cleared in the same cycle.
REQ-018 READ: read_valid SHALL be 1 and read_tracklet SHALL take the values 0, 1, 2, ... on consecutive cycles, one per cycle, with no gaps.
REQ-019 READ SHALL exit to DRAIN in the cycle after read_tracklet equals n_items-1; an n_items value of 1 gives exactly one read cycle.
REQ-020 DRAIN SHALL last exactly LATENCY cycles, then go to DONE; read_valid SHALL be 0 and read_tracklet SHALL hold its last value.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in READ, DRAIN and DONE, and 0 in IDLE.
REQ-023 Start edges that arrive while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 For each k, vm_wr_en_k SHALL equal vm_req_k AND NOT vm_full_k (combinational), and vm_wr_add_k SHALL equal the current value of counter k.
REQ-025 Counter k SHALL be ADDR_W+1 bits wide and SHALL increment by one on each qualified write; it SHALL NOT wrap.
REQ-026 vm_full_k SHALL be 1 when counter k equals 2^ADDR_W.
REQ-027 A request made while the target VM memory is full SHALL be dropped and SHALL set overflow, which stays set until the next accepted start.
REQ-028 The three VM channels SHALL be independent; simultaneous requests on all three SHALL all be accepted in the same cycle.
REQ-029 VM requests SHALL be honoured in every state, including IDLE, so that late writes are still accepted.

Reset
REQ-030 While reset=0, the FSM SHALL be in IDLE and read_tracklet, read_valid, busy, done, overflow, all counters, all vm_full_k and the registered copy of en_proc SHALL be 0.
REQ-031 An assertion of reset during any state SHALL abort the event immediately and SHALL NOT produce a done pulse.
REQ-032 If en_proc is already high when reset is released, no start SHALL occur until en_proc falls and rises again.

Configuration
REQ-033 With the macro TRACKLET_SEQ_ABORT_EN defined, the block SHALL add an input abort (1 bit): abort=1 in READ or DRAIN SHALL force IDLE on the next edge, with no done pulse and counters retained.
REQ-034 Without TRACKLET_SEQ_ABORT_EN, the abort port SHALL be absent and the FSM SHALL be uninterruptible except by reset.

Verification
REQ-035 n_items=5, LATENCY=2, pulse en_proc -> read_tracklet 0..4 with read_valid high for 5 cycles, 2 DRAIN cycles, done high for 1 cycle, busy high for 8 cycles.
REQ-036 n_items=0, start -> no read_valid; done high in the cycle after the start edge; busy high for 1 cycle.
REQ-037 vm_req_2 held high for 514 cycles -> vm_wr_add_2 takes 0..511, vm_full_2 rises after the 512th write, 2 writes dropped, overflow=1; channels 1 and 3 unaffected.
REQ-038 en_proc pulsed again in the middle of READ -> the sequence is unchanged and exactly one done pulse occurs; the next start after done clears overflow and the counters.
REQ-039 reset driven low with read_tracklet=3 in READ -> all outputs 0 asynchronously; en_proc held high through the reset release -> no start until en_proc toggles.
REQ-040 With TRACKLET_SEQ_ABORT_EN defined, abort asserted in DRAIN -> IDLE on the next edge, done stays 0, vm_wr_add values retained.
